dmem_copy_engine: RTL
=====================

# dmem_copy_engine

Bus-initiator block that drives the data-memory port (memRead, memWrite, address, data, and the returned memOut) to copy a block of words from a source region to a destination region, with a running checksum. It sits beside the pipeline's MEM stage as a second master of the data memory. The memory returns read data combinationally while memRead is high and commits writes on the falling clock edge; this block only issues accesses that fit that contract. Arbitration against the pipeline is external; while busy is high this block owns the port.

## Interface
- CNT_W, 16, width of the word-count input and internal index.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- srcAddr  input  32  word index of first source word.
- dstAddr  input  32  word index of first destination word.
- count  input  CNT_W  number of words to copy; 0 is legal.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse at completion.
- checksum  output  32  wrapping sum of all words read in the current or last transfer.
- memRead  output  1  read strobe to data memory.
- memWrite  output  1  write strobe to data memory.
- address  output  32  word address to data memory.
- data  output  32  write data to data memory.
- memIn  input  32  read data returned from the memory's memOut.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: all memory outputs are 0 and busy=0. When start=1, latch srcAddr, dstAddr and count, clear the index to 0 and clear checksum. Go to READ if count≠0, else go to DONE.
- READ: memRead=1, memWrite=0, address=srcLatched+index, data=0. At the rising edge, capture memIn into the word buffer, add memIn to checksum modulo 2^32, and go to WRITE.
- WRITE: memRead=0, memWrite=1, address=dstLatched+index, data=buffer. At the rising edge, increment the index. If the new index equals countLatched, go to DONE, else go to READ.
- DONE: all memory outputs are 0, busy=1, done=1. Next state is IDLE.
- Addresses are word indices incremented by 1, with 32-bit wrap-around. The memory itself uses only address[13:0].
- Copy order is strictly ascending. Overlapping regions therefore follow forward-copy semantics: with dst>src and overlap, the source pattern replicates. This is defined behaviour, not an error.
- memRead and memWrite are never high in the same cycle. The outputs are decoded from registered state only, so there are no combinational paths from inputs.
- Input changes while busy are ignored. start while busy is ignored and is not queued.
- checksum holds its value after DONE until the next accepted start.

## Timing
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, checksum=0, memRead=0, memWrite=0, address=0, data=0, index=0, buffer=0.
- Reset asserted mid-transfer aborts at once. memWrite falls before the next falling edge if rst rises in the first half of a WRITE cycle. Words already written remain; no done pulse is issued.
- Let start be sampled at rising edge E0. The cycle after E0 is READ for word 0 (count≠0). Word k occupies cycles 2k+1 (READ) and 2k+2 (WRITE). done=1 in cycle 2·count+1. The block is back in IDLE, able to accept a new start, in cycle 2·count+2.
- count=0: done=1 in cycle 1 with no memory strobes.
- Throughput is 2 cycles per word. The destination word is committed on the falling edge inside its WRITE cycle.
- A start presented in the DONE cycle is ignored; start is accepted only in IDLE.

## Test plan
- Memory preloaded with 10,15,19,13,20,24,11,45,23,31 at 1000..1009. Copy src=1000, dst=2000, count=10 → mem[2000..2009] match the source, checksum=211, done in cycle 21 only, busy cycles 1–21.
- count=0, src=1000, dst=3000 → done in cycle 1, memRead and memWrite never high, mem[3000]=0, checksum=0.
- Overlap with src=1000, dst=1001, count=3 → mem[1001..1003]=10,10,10, checksum=30, mem[1004]=20 unchanged.
- Start pulse in cycle 5 of a 10-word transfer with different src/dst → ignored; the original transfer completes with checksum=211, and no accesses go to the new addresses.
- rst raised during the WRITE of word 3 in the 10-word copy → all outputs 0 immediately, mem[2000..2002] copied, mem[2004..2009]=0, no done. A new start then completes normally.
- Every cycle of all tests: assert memRead and memWrite are never both high, and all memory outputs are 0 whenever busy=0.

Source files
------------

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: second data-memory master copying a word block src->dst with a running checksum
module dmem_copy_engine #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      srcAddr,
    input  logic [31:0]      dstAddr,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum,
    output logic             memRead,
    output logic             memWrite,
    output logic [31:0]      address,
    output logic [31:0]      data,
    input  logic [31:0]      memIn
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state, state_n;
    logic [31:0] src, dst, wbuf;
    logic [CNT_W-1:0] cnt, idx, idx_inc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src      <= '0;
            dst      <= '0;
            cnt      <= '0;
            idx      <= '0;
            wbuf     <= '0;
            checksum <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                src      <= srcAddr;
                dst      <= dstAddr;
                cnt      <= count;
                idx      <= '0;
                checksum <= '0;
            end
            if (state == READ) begin
                wbuf     <= memIn;
                checksum <= checksum + memIn;
            end
            if (state == WRITE) idx <= idx_inc;
        end
    end
    // every output is a decode of registered state, so nothing is combinational from inputs
    always_comb begin
        idx_inc  = idx + CNT_W'(1);
        state_n  = state == IDLE  ? (start ? (count != '0 ? READ : DONE) : IDLE) :
                   state == READ  ? WRITE :
                   state == WRITE ? (idx_inc == cnt ? DONE : READ) : IDLE;
        busy     = state != IDLE;
        done     = state == DONE;
        memRead  = state == READ;
        memWrite = state == WRITE;
        address  = memRead ? src + 32'(idx) : memWrite ? dst + 32'(idx) : '0;
        data     = memWrite ? wbuf : '0;
    end
endmodule
